// File: rtl/data_mem_pkg.sv
// Shared encodings for the CPU data-memory responder: load/store size codes,
// MMIO register offsets and ERR_STATUS bit positions.
package data_mem_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_e;

  localparam logic [3:0] OFF_GPIO    = 4'h0;
  localparam logic [3:0] OFF_CYC     = 4'h4;
  localparam logic [3:0] OFF_ERRST   = 4'h8;
  localparam logic [3:0] OFF_ERRADDR = 4'hC;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_UNMAPPED = 1;
  localparam int ERR_BADTYPE  = 2;
  localparam int ERR_W        = 3;

endpackage

// File: rtl/data_mem_if.sv
// CPU data-memory port: the CPU drives the request, the responder returns load data.
interface data_mem_if;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_wr_data;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic [31:0] MEM_data;

  modport master (
    output MEM_addr, MEM_wr_data, MEM_type, MEM_rd_en, MEM_wr_en,
    input  MEM_data
  );

  modport slave (
    input  MEM_addr, MEM_wr_data, MEM_type, MEM_rd_en, MEM_wr_en,
    output MEM_data
  );
endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for little-endian B/H/W accesses: store byte enables and
// replicated store data, load lane extraction, alignment and type checks.
module mem_lane_steer
  import data_mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  mem_type,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        misaligned,
  output logic        bad_type
);

  logic [31:0] rd_shifted;

  assign rd_shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    byte_en    = 4'b0000;
    wr_word    = 32'h0;
    rd_data    = 32'h0;
    misaligned = 1'b0;
    bad_type   = 1'b0;
    case (mem_type)
      MT_B, MT_BU: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wr_data[7:0]}};
        rd_data = {24'h0, rd_shifted[7:0]};
      end
      MT_H, MT_HU: begin
        misaligned = lane[0];
        byte_en    = 4'b0011 << lane;
        wr_word    = {2{wr_data[15:0]}};
        rd_data    = {16'h0, rd_shifted[15:0]};
      end
      MT_W: begin
        misaligned = (lane != 2'b00);
        byte_en    = 4'b1111;
        wr_word    = wr_data;
        rd_data    = rd_word;
      end
      default: bad_type = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: byte-steered word RAM plus a 16-byte MMIO window holding
// GPIO_OUT, a free-running cycle counter and sticky error status/address.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  data_mem_if.slave   mem,
  output logic [31:0] gpio_out,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]     gpio_reg;
  logic [31:0]     cyc_cnt_reg;
  logic [31:0]     cyc_cnt_next;
  logic [ERR_W-1:0] err_status_reg;
  logic [ERR_W-1:0] err_status_next;
  logic [31:0]     err_addr_reg;

  logic [AW-1:0]   word_idx;
  logic [3:0]      mmio_off;
  logic            req, in_ram, in_mmio, both_en, mmio_subword;
  logic [ERR_W-1:0] err_bits;
  logic [ERR_W-1:0] err_clr;
  logic            any_err, wr_ok, ram_we, mmio_we;
  logic [3:0]      byte_en;
  logic [31:0]     wr_word, rd_word, lane_rd_data, mmio_rd_data;
  logic            misaligned, bad_type;

  assign word_idx     = mem.MEM_addr[AW+1:2];
  assign mmio_off     = mem.MEM_addr[3:0];
  assign req          = mem.MEM_rd_en | mem.MEM_wr_en;
  assign in_ram       = ({2'b00, mem.MEM_addr[31:2]} < 32'(DEPTH));
  assign in_mmio      = (mem.MEM_addr[31:4] == MMIO_BASE[31:4]);
  assign both_en      = mem.MEM_rd_en & mem.MEM_wr_en;
  assign mmio_subword = in_mmio & (mem.MEM_type != MT_W);

  mem_lane_steer u_steer (
    .lane       (mem.MEM_addr[1:0]),
    .mem_type   (mem.MEM_type),
    .wr_data    (mem.MEM_wr_data),
    .rd_word    (rd_word),
    .byte_en    (byte_en),
    .wr_word    (wr_word),
    .rd_data    (lane_rd_data),
    .misaligned (misaligned),
    .bad_type   (bad_type)
  );

  always_comb begin
    err_bits               = '0;
    err_bits[ERR_MISALIGN] = req & misaligned;
    err_bits[ERR_UNMAPPED] = req & ~in_ram & ~in_mmio;
    err_bits[ERR_BADTYPE]  = req & (bad_type | mmio_subword | both_en);
  end

  // rd&wr together is itself an error, so a surviving write never coexists with a read.
  assign any_err = |err_bits;
  assign wr_ok   = mem.MEM_wr_en & ~any_err;
  assign ram_we  = wr_ok & in_ram;
  assign mmio_we = wr_ok & in_mmio;

  assign err_clr         = (mmio_we && mmio_off == OFF_ERRST) ? mem.MEM_wr_data[ERR_W-1:0] : '0;
  assign err_status_next = (err_status_reg & ~err_clr) | err_bits;
  assign cyc_cnt_next    = cyc_cnt_reg + 32'd1;

  // One byte-wide array per lane so stores touch only their enabled bytes.
  // The empty reset branch makes a store coinciding with reset get dropped.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
      end else if (ram_we && byte_en[gi]) begin
        lane_mem[word_idx] <= wr_word[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = lane_mem[word_idx];
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      gpio_reg       <= 32'h0;
      cyc_cnt_reg    <= 32'h0;
      err_status_reg <= '0;
      err_addr_reg   <= 32'h0;
    end else begin
      cyc_cnt_reg    <= cyc_cnt_next;
      err_status_reg <= err_status_next;
      if (mmio_we && mmio_off == OFF_GPIO) begin
        gpio_reg <= mem.MEM_wr_data;
      end
      if (any_err && err_status_reg == '0) begin
        err_addr_reg <= mem.MEM_addr;
      end
    end
  end

  always_comb begin
    mmio_rd_data = 32'h0;
    case (mmio_off)
      OFF_GPIO:    mmio_rd_data = gpio_reg;
      OFF_CYC:     mmio_rd_data = cyc_cnt_reg;
      OFF_ERRST:   mmio_rd_data = {{(32-ERR_W){1'b0}}, err_status_reg};
      OFF_ERRADDR: mmio_rd_data = err_addr_reg;
      default:     mmio_rd_data = 32'h0;
    endcase
  end

  always_comb begin
    mem.MEM_data = 32'h0;
    if (mem.MEM_rd_en && !any_err) begin
      mem.MEM_data = in_ram ? lane_rd_data : mmio_rd_data;
    end
  end

  assign gpio_out = gpio_reg;
  assign mem_err  = |err_status_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lane steering, MMIO registers,
// sticky error reporting, cycle counter wrap and asynchronous reset.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO = BASE + 32'h0;
  localparam logic [31:0] A_CYC  = BASE + 32'h4;
  localparam logic [31:0] A_ERST = BASE + 32'h8;
  localparam logic [31:0] A_EADR = BASE + 32'hC;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] gpio_out;
  logic        mem_err;
  int          checks = 0;
  int          errors = 0;

  data_mem_if mem_bus ();

  data_mem_responder #(.DEPTH(256), .MMIO_BASE(BASE)) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .mem      (mem_bus),
    .gpio_out (gpio_out),
    .mem_err  (mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    mem_bus.MEM_rd_en   = rd;
    mem_bus.MEM_wr_en   = wr;
    mem_bus.MEM_type    = t;
    mem_bus.MEM_addr    = a;
    mem_bus.MEM_wr_data = d;
  endtask

  // Every operation starts and ends at a falling edge, with one rising edge inside.
  task automatic store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, t, a, d);
    @(negedge CLK);
    drive(1'b0, 1'b0, MT_W, 32'h0, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] exp);
    drive(1'b1, 1'b0, t, a, 32'h0);
    #1 check(tag, mem_bus.MEM_data, exp);
    @(negedge CLK);
    drive(1'b0, 1'b0, MT_W, 32'h0, 32'h0);
  endtask

  logic [31:0] c0, c1;

  initial begin
    drive(1'b0, 1'b0, MT_W, 32'h0, 32'h0);
    repeat (2) @(negedge CLK);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_err", {31'h0, mem_err}, 32'h0);
    load_chk("rst_cyc", MT_W, A_CYC, 32'h0);
    Reset_n = 1'b1;
    @(negedge CLK);
    load_chk("rst_errst", MT_W, A_ERST, 32'h0);
    load_chk("rst_erraddr", MT_W, A_EADR, 32'h0);
    #1 check("idle_data", mem_bus.MEM_data, 32'h0);

    // RAM lane steering
    store(MT_W, 32'h10, 32'h1234_5678);
    store(MT_W, 32'h20, 32'h1122_3344);
    load_chk("lb_11", MT_B, 32'h11, 32'h0000_0056);
    load_chk("lhu_12", MT_HU, 32'h12, 32'h0000_1234);
    load_chk("lw_10", MT_W, 32'h10, 32'h1234_5678);
    load_chk("lbu_13", MT_BU, 32'h13, 32'h0000_0012);
    store(MT_B, 32'h13, 32'h0000_00AB);
    load_chk("sb_lw_10", MT_W, 32'h10, 32'hAB34_5678);
    store(MT_H, 32'h10, 32'hFFFF_BEEF);
    load_chk("sh_lw_10", MT_W, 32'h10, 32'hAB34_BEEF);
    load_chk("lh_12", MT_H, 32'h12, 32'h0000_AB34);

    // misaligned load and W1C
    load_chk("lw_02_data", MT_W, 32'h02, 32'h0);
    check("mis_mem_err", {31'h0, mem_err}, 32'h1);
    load_chk("mis_errst", MT_W, A_ERST, 32'h1);
    load_chk("mis_erraddr", MT_W, A_EADR, 32'h2);
    store(MT_W, A_ERST, 32'h4);
    load_chk("w1c_other", MT_W, A_ERST, 32'h1);
    store(MT_W, A_ERST, 32'h1);
    load_chk("w1c_clear", MT_W, A_ERST, 32'h0);
    check("clr_mem_err", {31'h0, mem_err}, 32'h0);

    // GPIO, sub-word MMIO, unmapped
    store(MT_W, A_GPIO, 32'hDEAD_BEEF);
    check("gpio_out", gpio_out, 32'hDEAD_BEEF);
    load_chk("gpio_rd", MT_W, A_GPIO, 32'hDEAD_BEEF);
    store(MT_B, A_GPIO, 32'h0000_0011);
    check("gpio_sb_kept", gpio_out, 32'hDEAD_BEEF);
    load_chk("subword_errst", MT_W, A_ERST, 32'h4);
    load_chk("unmapped_data", MT_W, 32'h400, 32'h0);
    load_chk("unmapped_errst", MT_W, A_ERST, 32'h6);
    load_chk("first_erraddr", MT_W, A_EADR, BASE);
    store(MT_W, A_CYC, 32'h0);
    store(MT_W, A_ERST, 32'h7);
    load_chk("clr_all", MT_W, A_ERST, 32'h0);

    // reserved type and rd+wr together
    load_chk("rsvd_data", 3'b011, 32'h10, 32'h0);
    load_chk("rsvd_errst", MT_W, A_ERST, 32'h4);
    load_chk("rsvd_erraddr", MT_W, A_EADR, 32'h10);
    store(MT_W, A_ERST, 32'h7);
    drive(1'b1, 1'b1, MT_W, 32'h10, 32'h5555_5555);
    #1 check("rdwr_data", mem_bus.MEM_data, 32'h0);
    @(negedge CLK);
    load_chk("rdwr_errst", MT_W, A_ERST, 32'h4);
    load_chk("rdwr_nowrite", MT_W, 32'h10, 32'hAB34_BEEF);
    store(MT_W, A_ERST, 32'h7);

    // cycle counter
    drive(1'b1, 1'b0, MT_W, A_CYC, 32'h0);
    #1 c0 = mem_bus.MEM_data;
    repeat (5) @(negedge CLK);
    #1 c1 = mem_bus.MEM_data;
    check("cyc_delta", c1 - c0, 32'd5);
    @(negedge CLK);
    force dut.cyc_cnt_next = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.cyc_cnt_next;
    load_chk("cyc_max", MT_W, A_CYC, 32'hFFFF_FFFF);
    load_chk("cyc_wrap", MT_W, A_CYC, 32'h0);

    // asynchronous reset with a store in flight
    store(MT_W, A_GPIO, 32'hA5A5_A5A5);
    load_chk("pre_rst_err", MT_W, 32'h03, 32'h0);
    check("pre_rst_mem_err", {31'h0, mem_err}, 32'h1);
    drive(1'b0, 1'b1, MT_W, 32'h20, 32'h5566_7788);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_gpio", gpio_out, 32'h0);
    check("arst_mem_err", {31'h0, mem_err}, 32'h0);
    check("arst_data", mem_bus.MEM_data, 32'h0);
    @(negedge CLK);
    drive(1'b0, 1'b0, MT_W, 32'h0, 32'h0);
    Reset_n = 1'b1;
    @(negedge CLK);
    load_chk("store_dropped", MT_W, 32'h20, 32'h1122_3344);
    load_chk("post_rst_errst", MT_W, A_ERST, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
